// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: handshake/data bundle between the ID/EX stage, the hazard
// logic and the iterative multiply/divide unit.
//   start_i  : ID/EX holds a valid mult/div instruction this cycle
//   op_i     : 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   Data1_i  : rs operand (multiplicand / dividend)
//   Data2_i  : rt operand (multiplier / divisor)
//   rdreq_i  : ID/EX holds MFHI or MFLO this cycle
//   hi_o/lo_o: architectural HI/LO registers
//   busy_o   : unit not idle
//   done_o   : one-cycle pulse after HI/LO were updated
//   stall_o  : combinational stall request to the hazard logic
// Modport master drives the requests; modport slave is the unit itself.
interface ex_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] Data1_i;
  logic [WIDTH-1:0] Data2_i;
  logic             rdreq_i;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             busy_o;
  logic             done_o;
  logic             stall_o;

  modport master (
    output start_i, op_i, Data1_i, Data2_i, rdreq_i,
    input  hi_o, lo_o, busy_o, done_o, stall_o
  );

  modport slave (
    input  start_i, op_i, Data1_i, Data2_i, rdreq_i,
    output hi_o, lo_o, busy_o, done_o, stall_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU/DIV/DIVU unit for the EX stage.
// One operation takes ITER iteration cycles (RUN) plus one sign-fix cycle
// (FIX); HI/LO are written on the FIX -> IDLE edge and done_o pulses in the
// following cycle. While busy, a new start or an MFHI/MFLO read raises the
// combinational stall_o so the pipeline holds the instruction in ID/EX.
// Ports:
//   clk_i : rising-edge clock
//   rst_i : asynchronous active-high reset (aborts any running operation)
//   bus   : ex_muldiv_if.slave, see the interface file for signal meanings
module ex_muldiv #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic         clk_i,
  input  logic         rst_i,
  ex_muldiv_if.slave   bus
);

  localparam int CNT_W = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0]   cnt_reg;
  logic [1:0]         op_reg;
  logic               sign_a_reg;
  logic               sign_b_reg;
  logic               div_zero_reg;
  // Operand added (multiply) or subtracted (divide) on every iteration.
  logic [WIDTH-1:0]   opnd_reg;
  // Multiply: {partial high, remaining multiplier bits}.
  // Divide:   {partial remainder, remaining dividend bits / quotient bits}.
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               done_reg;

  logic               is_div;
  logic               signed_op;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     div_diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign is_div    = op_reg[1];
  assign signed_op = op_reg[0];

  // Magnitudes of the incoming operands. Negating 0x80000000 yields
  // 0x80000000, which is the correct unsigned magnitude.
  assign mag1 = (bus.op_i[0] && bus.Data1_i[WIDTH-1]) ? -bus.Data1_i : bus.Data1_i;
  assign mag2 = (bus.op_i[0] && bus.Data2_i[WIDTH-1]) ? -bus.Data2_i : bus.Data2_i;

  // Shift-add multiply step, LSB first: add the multiplicand into the high
  // half when the current multiplier bit is set, then shift right keeping
  // the carry.
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                  + (acc_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

  // Restoring divide step, MSB first: shift the next dividend bit into the
  // remainder, trial-subtract the divisor, keep the difference if it did not
  // go negative. Quotient bits fill the low half from the right.
  assign rem_sh   = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, opnd_reg};
  assign q_bit    = ~div_diff[WIDTH];
  assign rem_new  = q_bit ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign div_next = {rem_new, acc_reg[WIDTH-2:0], q_bit};

  // Sign correction applied in FIX.
  assign product = (signed_op && (sign_a_reg ^ sign_b_reg)) ? -acc_reg : acc_reg;
  // A zero divisor leaves the dividend magnitude as remainder, so after the
  // sign fix HI already equals the raw dividend; only LO needs forcing.
  assign quo_fix = div_zero_reg ? {WIDTH{1'b1}} :
                   (signed_op && (sign_a_reg ^ sign_b_reg)) ? -acc_reg[WIDTH-1:0]
                                                            : acc_reg[WIDTH-1:0];
  assign rem_fix = (signed_op && sign_a_reg) ? -acc_reg[2*WIDTH-1:WIDTH]
                                             : acc_reg[2*WIDTH-1:WIDTH];
  assign fix_hi  = is_div ? rem_fix : product[2*WIDTH-1:WIDTH];
  assign fix_lo  = is_div ? quo_fix : product[WIDTH-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.start_i) state_next = RUN;
      RUN:  if (cnt_reg == CNT_W'(ITER - 1)) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg      <= '0;
      op_reg       <= '0;
      sign_a_reg   <= 1'b0;
      sign_b_reg   <= 1'b0;
      div_zero_reg <= 1'b0;
      opnd_reg     <= '0;
      acc_reg      <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start_i) begin
            op_reg       <= bus.op_i;
            sign_a_reg   <= bus.op_i[0] & bus.Data1_i[WIDTH-1];
            sign_b_reg   <= bus.op_i[0] & bus.Data2_i[WIDTH-1];
            div_zero_reg <= bus.op_i[1] & (bus.Data2_i == '0);
            cnt_reg      <= '0;
            // High half (partial product / remainder) starts cleared; the
            // low half holds the bits consumed one per iteration.
            if (bus.op_i[1]) begin
              opnd_reg <= mag2;
              acc_reg  <= {{WIDTH{1'b0}}, mag1};
            end else begin
              opnd_reg <= mag1;
              acc_reg  <= {{WIDTH{1'b0}}, mag2};
            end
          end
        end
        RUN: begin
          acc_reg <= is_div ? div_next : mul_next;
          cnt_reg <= cnt_reg + 1'b1;
        end
        FIX: begin
          hi_reg   <= fix_hi;
          lo_reg   <= fix_lo;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi_o    = hi_reg;
  assign bus.lo_o    = lo_reg;
  assign bus.busy_o  = (state_reg != IDLE);
  assign bus.done_o  = done_reg;
  assign bus.stall_o = bus.busy_o & (bus.start_i | bus.rdreq_i);

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed test of ex_muldiv. Stimulus pushes the hand-computed
// HI/LO into a queue; a monitor pops and compares on every done_o pulse.
module tb_ex_muldiv;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  ex_muldiv_if #(.WIDTH(32)) bus();

  ex_muldiv #(.WIDTH(32), .ITER(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && bus.done_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got hi=%h lo=%h required no result", bus.hi_o, bus.lo_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_hi", bus.hi_o, mon_e.hi);
        check("result_lo", bus.lo_o, mon_e.lo);
        $display("result hi=%h lo=%h (expected hi=%h lo=%h)", bus.hi_o, bus.lo_o, mon_e.hi, mon_e.lo);
      end
    end
  end

  // Issue one operation and follow it to completion. With hz set, a start
  // is attempted at busy cycle 10 and an MFHI/MFLO read during FIX and in
  // the first idle cycle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input bit hz);
    int k;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.Data1_i = a;
    bus.Data2_i = b;
    exp_q.push_back('{hi: eh, lo: el});
    #1 check("stall_idle_start", {31'd0, bus.stall_o}, 32'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    k = 0;
    while (bus.busy_o === 1'b1 && k < 100) begin
      k++;
      if (hz && k == 10) begin
        bus.start_i = 1'b1;
        bus.op_i    = 2'b00;
        bus.Data1_i = 32'd5;
        bus.Data2_i = 32'd6;
        #1 check("stall_on_start", {31'd0, bus.stall_o}, 32'd1);
      end else begin
        bus.start_i = 1'b0;
      end
      if (hz && k == 33) begin
        bus.rdreq_i = 1'b1;
        #1 check("stall_rd_fix", {31'd0, bus.stall_o}, 32'd1);
      end
      @(negedge clk);
    end
    $display("op=%0d a=%h b=%h busy_cycles=%0d", op, a, b, k);
    check("busy_cycles", k, 33);
    check("done_high", {31'd0, bus.done_o}, 32'd1);
    if (hz) begin
      #1;
      check("stall_rd_idle", {31'd0, bus.stall_o}, 32'd0);
      check("rd_idle_hi", bus.hi_o, eh);
      bus.rdreq_i = 1'b0;
    end
    @(negedge clk);
    check("done_pulse_end", {31'd0, bus.done_o}, 32'd0);
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.op_i    = 2'b00;
    bus.Data1_i = 32'd0;
    bus.Data2_i = 32'd0;
    bus.rdreq_i = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_hi", bus.hi_o, 32'd0);
    check("rst_lo", bus.lo_o, 32'd0);
    check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("rst_done", {31'd0, bus.done_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op(2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op(2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op(2'b10, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b0);
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op(2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b1);

    // Reset at busy cycle 15 aborts the operation; no result is expected.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = 2'b00;
    bus.Data1_i = 32'd9;
    bus.Data2_i = 32'd9;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (14) @(negedge clk);
    check("busy_before_rst", {31'd0, bus.busy_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_hi", bus.hi_o, 32'd0);
    check("midrst_lo", bus.lo_o, 32'd0);
    check("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
    $display("mid-run reset applied");
    @(negedge clk);
    rst = 1'b0;

    run_op(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

    @(negedge clk);
    check("results_pending", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion required finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage. It consumes the operands and decoded operation held in the ID/EX pipeline register and computes MULT/MULTU/DIV/DIVU over 33 cycles into architectural HI/LO registers. While busy, it returns a stall request to the hazard logic, which freezes PC, IF/ID and ID/EX. It is the downstream reader of the ID/EX register for the multi-cycle instruction class.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, WIDTH, number of iteration cycles in RUN.

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  rising-edge clock, shared with the pipeline registers
- rst_i  in  1  asynchronous active-high reset
- start_i  in  1  ID/EX holds a valid mult/div instruction this cycle
- op_i  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- Data1_i  in  WIDTH  rs operand from ID/EX (multiplicand / dividend)
- Data2_i  in  WIDTH  rt operand from ID/EX (multiplier / divisor)
- rdreq_i  in  1  ID/EX holds MFHI or MFLO this cycle
- hi_o  out  WIDTH  HI register
- lo_o  out  WIDTH  LO register
- busy_o  out  1  unit not IDLE
- done_o  out  1  one-cycle pulse; HI/LO were just updated
- stall_o  out  1  stall request to hazard logic; equals busy_o & (start_i | rdreq_i), combinational

## Operation
- States: IDLE, RUN, FIX.
  - IDLE → RUN: on start_i.
  - RUN → FIX: after ITER iterations.
  - FIX → IDLE: always.
- busy_o is 1 in RUN and FIX.
- IDLE with start_i:
  - Latch op_i and the operand signs.
  - Latch operand magnitudes: absolute values for MULT/DIV, raw values for MULTU/DIVU. A magnitude of 0x80000000 is held correctly as unsigned.
  - Clear the iteration counter and the partial accumulator.
- RUN, multiply: one shift-add step per cycle, LSB-first, into a 2×WIDTH accumulator.
- RUN, divide: one restoring-division step per cycle, MSB-first; produces quotient and remainder magnitudes.
- FIX, multiply:
  - For MULT with differing signs, negate the 64-bit product.
  - HI = product[63:32], LO = product[31:0].
- FIX, divide:
  - LO = quotient; negated when the signs differ (DIV only).
  - HI = remainder; carries the dividend's sign (DIV only).
- Divide by zero: same latency; HI = Data1 as latched, LO = all ones. No exception is raised.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- start_i while busy_o: ignored. The running operation is unaffected and stall_o = 1. The hazard logic holds ID/EX, so the instruction is reissued once the unit returns to IDLE.
- rdreq_i while busy_o (including FIX): stall_o = 1. MFHI/MFLO therefore always read completed results.
- rdreq_i in IDLE: no stall; the current HI/LO are read.
- HI/LO change only on the FIX → IDLE edge, or on reset.

## Timing
- Reset values, applied asynchronously: state IDLE; hi_o = lo_o = 0; busy_o = 0; done_o = 0; counter and accumulators 0.
- Reset mid-operation aborts immediately. The partial result is discarded and HI/LO become 0.
- Cycle sequence, with E0 the edge sampling start_i in IDLE:
  - E1..E32: the 32 iterations.
  - E32: RUN → FIX.
  - E33: HI/LO written; FIX → IDLE.
- busy_o is high from after E0 until E33: 33 cycles.
- done_o is high for exactly the cycle after E33, registered.
- A new start_i may be sampled at E33+1 (first IDLE cycle). Back-to-back throughput is one op per 34 cycles.
- stall_o has no registered delay. The hazard logic must see it in the same cycle as start_i or rdreq_i.

## Test plan
- Reset: pulse rst_i asynchronously between edges → hi_o = lo_o = 0, busy_o = 0 and done_o = 0 immediately; no clock is required.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → busy_o for 33 cycles; after E33, HI = 0xFFFFFFFE and LO = 0x00000001; done_o for 1 cycle.
- MULT 0xFFFFFFFD (−3) × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- DIV 0xFFFFFFF9 (−7) / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Then DIVU 7 / 0 → HI = 7, LO = 0xFFFFFFFF, same latency.
- Hazards:
  - Assert start_i (MULTU 5 × 6) at cycle 10 of a running DIVU 100 / 7 → stall_o = 1; result HI = 2, LO = 14 is unaffected.
  - Assert rdreq_i during FIX → stall_o = 1.
  - Assert rdreq_i in the cycle after E33 → stall_o = 0 and hi_o is the new value.
- Assert rst_i at cycle 15 of RUN → IDLE, HI/LO = 0 and busy_o = 0 immediately. Then MULTU 3 × 4 completes with LO = 12, HI = 0 after 33 cycles.
